// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bus bundle between the two requesters (instruction fetch, load/store)
//   and the single-port memory arbiter, plus the memory-side signals.
//
//   Requester IF : if_req, if_addr -> arbiter ; if_rdata, if_ack <- arbiter
//   Requester D  : d_req, d_we, d_addr, d_wdata -> arbiter ; d_rdata, d_ack <- arbiter
//   Memory       : mem_en, mem_we, mem_addr, mem_wdata <- arbiter ; mem_rdata -> arbiter
//
//   modport master : the arbiter's view
//   modport slave  : the environment's view (requesters and memory)
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch
//   (IF) and load/store (D). D has fixed priority. Each access runs
//   IDLE -> ISSUE -> WAIT -> DONE: the grant edge registers the address and
//   controls, ISSUE pulses mem_en, WAIT counts MEM_LAT cycles and captures
//   read data on the last one, DONE pulses the winner's ack.
//
//   Ports
//     clock    : system clock, rising edge
//     reset    : synchronous, active-high
//     bus      : mem_port_arbiter_if.master (requester and memory signals)
//     busy     : high whenever the FSM is not IDLE
//     grant_d  : current or last owner, 1 = D, 0 = IF
//
//   Optional build macro ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive
//   D grants made while IF was waiting, the next grant is forced to IF.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.master  bus,
  output logic                busy,
  output logic                grant_d
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  lat_cnt;
  logic              grant_any;
  logic              grant_to_d;
  logic              force_if;
  logic [ADDR_W-1:0] grant_addr;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_cnt;

  assign force_if = (starve_cnt == STARVE_W'(STARVE_MAX)) && bus.if_req;

  // Counts D grants that overtook a waiting IF; any IF grant clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_any) begin
      if (!grant_to_d)
        starve_cnt <= '0;
      else if (bus.if_req && (starve_cnt != STARVE_W'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign force_if = 1'b0;
  wire unused_starve_max = (STARVE_MAX > 0);
`endif

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: state is assigned with <= so every register in this block sees
    // the pre-edge value of every other register, as real flops would.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, grant decision and strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    state_nxt   = state;
    grant_any   = 1'b0;
    grant_to_d  = 1'b0;
    bus.mem_en  = 1'b0;
    bus.if_ack  = 1'b0;
    bus.d_ack   = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.d_req && !force_if) begin
          grant_any  = 1'b1;
          grant_to_d = 1'b1;
          state_nxt  = ISSUE;
        end else if (bus.if_req) begin
          grant_any  = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        // The counter reaches zero at this edge: the read data is valid now.
        if (lat_cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (grant_d) bus.d_ack  = 1'b1;
        else         bus.if_ack = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    grant_addr = grant_to_d ? bus.d_addr : bus.if_addr;
  end

  // Datapath: request capture at the grant edge, latency count, read capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.d_rdata   <= {DATA_W{1'b0}};
      grant_d       <= 1'b0;
      lat_cnt       <= '0;
    end else begin
      if (grant_any) begin
        grant_d       <= grant_to_d;
        bus.mem_addr  <= grant_addr;
        bus.mem_we    <= grant_to_d & bus.d_we;
        bus.mem_wdata <= bus.d_wdata;
      end
      if (state == ISSUE) begin
        lat_cnt <= CNT_W'(MEM_LAT);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
        if ((lat_cnt == CNT_W'(1)) && !bus.mem_we) begin
          if (grant_d) bus.d_rdata  <= bus.mem_rdata;
          else         bus.if_rdata <= bus.mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiters (MEM_LAT=1 and MEM_LAT=3) driven by directed steps. Each
//   step pushes its expected memory accesses and acks into per-DUT queues;
//   negedge monitors pop and compare them, including cycle of arrival.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    int          cyc;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    int          cyc;
    logic        is_d;
    logic        we;
    logic [DW-1:0] rdata;
  } ack_exp_t;

  logic clock = 1'b0;
  logic reset1, reset3;
  logic busy1, gd1, busy3, gd3;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_exp_t mq1[$], mq3[$];
  ack_exp_t aq1[$], aq3[$];
  logic [DW-1:0] if_rd1, d_rd1, if_rd3, d_rd3;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clock(clock), .reset(reset1), .bus(b1), .busy(busy1), .grant_d(gd1));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clock(clock), .reset(reset3), .bus(b3), .busy(busy3), .grant_d(gd3));

  // Memory model: contents are a fixed function of address; read data is
  // presented only in the single cycle MEM_LAT cycles after mem_en.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_A5A5;
  endfunction

  logic [DW:0] pipe1 = '0;
  logic [DW:0] pipe3 [3] = '{default: '0};
  always @(posedge clock) begin
    pipe1    <= (b1.mem_en && !b1.mem_we) ? {1'b1, mem_val(b1.mem_addr)} : '0;
    pipe3[0] <= (b3.mem_en && !b3.mem_we) ? {1'b1, mem_val(b3.mem_addr)} : '0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b1.mem_rdata = pipe1[DW]    ? pipe1[DW-1:0]    : 32'hBAD0_BAD0;
  assign b3.mem_rdata = pipe3[2][DW] ? pipe3[2][DW-1:0] : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // s = cycle count right after the grant edge; ack arrives MEM_LAT+1 later.
  task automatic exp1(input int s, input logic is_d, input logic we,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    mq1.push_back('{s, we, addr, wdata});
    aq1.push_back('{s + 2, is_d, we, we ? 32'h0 : mem_val(addr)});
  endtask

  task automatic exp3(input int s, input logic is_d, input logic we,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    mq3.push_back('{s, we, addr, wdata});
    aq3.push_back('{s + 4, is_d, we, we ? 32'h0 : mem_val(addr)});
  endtask

  // Monitor for the MEM_LAT=1 arbiter.
  always @(negedge clock) begin
    if (reset1) begin
      if_rd1 = '0;
      d_rd1  = '0;
    end else begin
      if (b1.mem_en) begin
        check("d1 mem_en expected", mq1.size() != 0, 1);
        if (mq1.size() != 0) begin
          mem_exp_t e;
          e = mq1.pop_front();
          check("d1 mem_en cycle", cyc, e.cyc);
          check("d1 mem_we", b1.mem_we, e.we);
          check("d1 mem_addr", b1.mem_addr, e.addr);
          if (e.we) check("d1 mem_wdata", b1.mem_wdata, e.wdata);
        end
      end
      if (b1.if_ack || b1.d_ack) begin
        check("d1 ack expected", aq1.size() != 0, 1);
        check("d1 both acks", b1.if_ack & b1.d_ack, 0);
        if (aq1.size() != 0) begin
          ack_exp_t a;
          a = aq1.pop_front();
          check("d1 ack cycle", cyc, a.cyc);
          check("d1 ack owner", b1.d_ack, a.is_d);
          if (!a.we) begin
            if (a.is_d) d_rd1 = a.rdata;
            else        if_rd1 = a.rdata;
          end
          check("d1 if_rdata", b1.if_rdata, if_rd1);
          check("d1 d_rdata", b1.d_rdata, d_rd1);
        end
      end
    end
  end

  // Monitor for the MEM_LAT=3 arbiter.
  always @(negedge clock) begin
    if (reset3) begin
      if_rd3 = '0;
      d_rd3  = '0;
    end else begin
      if (b3.mem_en) begin
        check("d3 mem_en expected", mq3.size() != 0, 1);
        if (mq3.size() != 0) begin
          mem_exp_t e;
          e = mq3.pop_front();
          check("d3 mem_en cycle", cyc, e.cyc);
          check("d3 mem_we", b3.mem_we, e.we);
          check("d3 mem_addr", b3.mem_addr, e.addr);
        end
      end
      if (b3.if_ack || b3.d_ack) begin
        check("d3 ack expected", aq3.size() != 0, 1);
        check("d3 both acks", b3.if_ack & b3.d_ack, 0);
        if (aq3.size() != 0) begin
          ack_exp_t a;
          a = aq3.pop_front();
          check("d3 ack cycle", cyc, a.cyc);
          check("d3 ack owner", b3.d_ack, a.is_d);
          if (!a.we) begin
            if (a.is_d) d_rd3 = a.rdata;
            else        if_rd3 = a.rdata;
          end
          check("d3 if_rdata", b3.if_rdata, if_rd3);
          check("d3 d_rdata", b3.d_rdata, d_rd3);
        end
      end
    end
  end

  initial begin
    int s;
    reset1 = 1'b1;  reset3 = 1'b1;
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
    tick(3);

    // Reset state.
    check("rst busy", busy1, 0);
    check("rst grant_d", gd1, 0);
    check("rst mem_en", b1.mem_en, 0);
    check("rst mem_we", b1.mem_we, 0);
    check("rst mem_addr", b1.mem_addr, 0);
    check("rst mem_wdata", b1.mem_wdata, 0);
    check("rst acks", {b1.if_ack, b1.d_ack}, 0);
    check("rst rdata", {b1.if_rdata, b1.d_rdata}, 0);
    check("rst d3 busy", busy3, 0);
    reset1 = 1'b0;  reset3 = 1'b0;
    tick(1);

    // IF read of 0x10; address change after the grant edge is ignored.
    s = cyc + 1;
    b1.if_req = 1; b1.if_addr = 32'h10;
    exp1(s, 0, 0, 32'h10, '0);
    tick(1);
    check("if read busy", busy1, 1);
    b1.if_addr = 32'h99;
    tick(2);
    b1.if_req = 0;
    tick(1);
    check("if read idle", busy1, 0);
    check("if read owner", gd1, 0);
    tick(1);

    // D write; request drops before ack and the access still completes.
    s = cyc + 1;
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h20; b1.d_wdata = 32'h1234_5678;
    exp1(s, 1, 1, 32'h20, 32'h1234_5678);
    tick(1);
    b1.d_req = 0; b1.d_wdata = 32'h0; b1.d_we = 0;
    check("d write owner", gd1, 1);
    tick(3);
    check("d write mem_we held", b1.mem_we, 1);
    check("d write mem_addr held", b1.mem_addr, 32'h20);

    // Simultaneous reads: D (0x80) first, IF (0x40) one slot later.
    s = cyc + 1;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h80;
    b1.if_req = 1; b1.if_addr = 32'h40;
    exp1(s, 1, 0, 32'h80, '0);
    exp1(s + 4, 0, 0, 32'h40, '0);
    tick(3);
    b1.d_req = 0;
    tick(4);
    b1.if_req = 0;
    check("simul last owner", gd1, 0);
    tick(2);

    // MEM_LAT=3 IF read: busy for exactly five cycles.
    s = cyc + 1;
    b3.if_req = 1; b3.if_addr = 32'h30;
    exp3(s, 0, 0, 32'h30, '0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check($sformatf("d3 busy c%0d", i), busy3, (i < 5) ? 1'b1 : 1'b0);
      if (i == 4) b3.if_req = 0;
    end
    tick(1);

    // Reset during WAIT abandons the access without an ack.
    s = cyc + 1;
    b3.if_req = 1; b3.if_addr = 32'h50;
    mq3.push_back('{s, 1'b0, 32'h50, 32'h0});
    tick(2);
    check("d3 in wait", busy3, 1);
    reset3 = 1'b1; b3.if_req = 0;
    tick(1);
    check("d3 abort busy", busy3, 0);
    check("d3 abort mem_en", b3.mem_en, 0);
    check("d3 abort ack", {b3.if_ack, b3.d_ack}, 0);
    check("d3 abort if_rdata", b3.if_rdata, 0);
    reset3 = 1'b0;
    tick(4);

    // Normal D read after the abort.
    s = cyc + 1;
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h60;
    exp3(s, 1, 0, 32'h60, '0);
    tick(5);
    b3.d_req = 0;
    tick(2);

    // Both requests held for six grants.
    s = cyc + 1;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h100;
    b1.if_req = 1; b1.if_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (k == 4) exp1(s + 4 * k, 0, 0, 32'h200, '0);
      else        exp1(s + 4 * k, 1, 0, 32'h100, '0);
`else
      exp1(s + 4 * k, 1, 0, 32'h100, '0);
`endif
    end
    tick(23);
    b1.d_req = 0; b1.if_req = 0;
    tick(4);

    check("d1 pending mem accesses", mq1.size(), 0);
    check("d1 pending acks", aq1.size(), 0);
    check("d3 pending mem accesses", mq3.size(), 0);
    check("d3 pending acks", aq3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between two requesters: instruction fetch (IF) and load/store (data, D).
- Sits between the core pipeline and the memory inside Top.
- Arbitrates, sequences each access through a fixed-latency memory, and returns a one-cycle ack with read data.
- D has fixed priority over IF. An optional guard prevents IF starvation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid MEM_LAT cycles after the mem_en cycle.
- STARVE_MAX, 4, consecutive D grants with IF pending before IF is forced (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetch read data; valid in the if_ack cycle.
- if_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; valid in the d_ack cycle.
- d_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in any state other than IDLE.
- grant_d  out  1  current or last owner: 1 = D, 0 = IF.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on port `reset`.
- Reset: all outputs 0, state IDLE, starvation counter 0. Reset mid-transaction abandons the access; no ack is issued.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Samples requests at each edge.
  - If d_req=1, grant D; else if if_req=1, grant IF; else stay in IDLE.
  - On grant, register mem_addr, mem_we, mem_wdata and grant_d from the winner. mem_we is forced 0 for IF; mem_wdata is don't-care for IF.
- ISSUE: mem_en=1 for exactly one cycle. Load a latency counter with MEM_LAT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0 at an edge, capture mem_rdata into the winner's rdata register.
  - rdata for the non-winner is unchanged.
  - Writes take the same latency; the rdata register is unchanged on a write.
- DONE: the winner's ack=1 for one cycle, then IDLE. Requests are not sampled in DONE.
- Latency: request sampled at edge 0 -> mem_en in cycle 1 -> ack in cycle MEM_LAT+2. Throughput: one access per MEM_LAT+3 cycles.
- Requester rules:
  - Requester deasserts req in the cycle after ack; otherwise a new identical access begins.
  - If req drops before ack, the transaction still completes and the ack still pulses.
- Simultaneous d_req and if_req in IDLE: D wins, IF waits.
- Address and data inputs are sampled only at the grant edge; later changes are ignored.
- mem_addr and mem_we hold their values after the transaction until the next grant.
- if_ack and d_ack are never high in the same cycle.

Optional Feature:
Macro: ARB_STARVE_GUARD_EN
- Defined:
  - A counter increments on each D grant made while if_req=1, saturating at STARVE_MAX.
  - At STARVE_MAX, the next IDLE grant goes to IF even if d_req=1.
  - The counter clears on any IF grant.
- Undefined: pure fixed D priority; the counter is not built.

Test Plan:
- Reset, then IF read: if_addr=0x10, mem returns 0xDEADBEEF, MEM_LAT=1 -> mem_en in cycle 1 with mem_addr=0x10, if_ack in cycle 3, if_rdata=0xDEADBEEF.
- D write: d_we=1, d_addr=0x20, d_wdata=0x12345678 -> one mem_en cycle with mem_we=1 and mem_wdata=0x12345678, d_ack after MEM_LAT+2 cycles, d_rdata unchanged.
- Simultaneous if_req and d_req (both reads, 0x40 and 0x80) -> D served first (mem_addr=0x80), IF served next (mem_addr=0x40), acks MEM_LAT+3 cycles apart.
- MEM_LAT=3, IF read -> if_ack exactly 5 cycles after request sampling; busy high for 5 cycles.
- Reset asserted during WAIT -> next cycle busy=0, no ack, mem_en=0. A subsequent request behaves normally.
- With ARB_STARVE_GUARD_EN and STARVE_MAX=4, both reqs held high -> 4 D grants, then 1 IF grant, then D again. Without the macro, IF is never granted.
